pad_bus_ctrl: RTL

- Core-side companion to the chip pad ring. Sits between the CPU core and the pad cells.
- Synchronises and glitch-filters the asynchronous interrupt pins and turns NMI into a pending flag.
- Registers all outbound address and control strobes.
- Owns the bidirectional data-bus direction with guaranteed turnaround (bus-release) cycles, so the data pad output enable is never driven straight from core logic.

---
 rtl/pad_pkg.sv | 22 ++
 rtl/pad_irq_filter.sv | 44 ++++
 rtl/pad_bus_ctrl.sv | 117 +++++++++++
 3 files changed

// File: rtl/pad_pkg.sv
// Shared types and constants for the pad-ring companion logic.
package pad_pkg;

  typedef enum logic [1:0] {
    ST_IN       = 2'd0,
    ST_TURN_OUT = 2'd1,
    ST_OUT      = 2'd2,
    ST_TURN_IN  = 2'd3
  } bus_state_e;

  localparam int IORQ = 0;
  localparam int HALT = 1;
  localparam int M1   = 2;
  localparam int MREQ = 3;
  localparam int RD   = 4;
  localparam int WR   = 5;

  // Strobes are active low, so idle is all ones.
  localparam logic       STROBE_IDLE = 1'b1;
  localparam logic [5:0] CTRL_RST_N  = 6'h3F;

endpackage

// File: rtl/pad_irq_filter.sv
// One interrupt pin: synchroniser chain followed by a change-qualification counter.
module pad_irq_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic pin_n_i,
  output logic irq_n_o
);
  localparam int CW = $clog2(FILT_LEN + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILT_LEN - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   irq_q, irq_d;
  logic                   s;

  assign s       = sync_q[SYNC_STAGES-1];
  assign irq_n_o = irq_q;

  // The sample that completes FILT_LEN differing samples flips the output.
  always_comb begin
    cnt_d = '0;
    irq_d = irq_q;
    if (s != irq_q) begin
      if (cnt_q == CNT_LAST) irq_d = s;
      else                   cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '1;
      cnt_q  <= '0;
      irq_q  <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin_n_i};
      cnt_q  <= cnt_d;
      irq_q  <= irq_d;
    end
  end

endmodule

// File: rtl/pad_bus_ctrl.sv
// Core-side pad ring companion: interrupt conditioning, registered strobes and
// data-bus direction control with enforced turnaround cycles.
module pad_bus_ctrl
  import pad_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 8,
  parameter int CTRL_W      = 6,
  parameter int N_IRQ       = 2,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3,
  parameter int TURN_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_IRQ-1:0]  pad_irq_n,
  output logic [N_IRQ-1:0]  irq_n,
  output logic              nmi_pending,
  input  logic              nmi_ack,
  input  logic [ADDR_W-1:0] addr,
  input  logic [CTRL_W-1:0] ctrl_n,
  output logic [ADDR_W-1:0] pad_addr,
  output logic [CTRL_W-1:0] pad_ctrl_n,
  input  logic [DATA_W-1:0] data_out,
  input  logic              data_out_en,
  output logic              drive_ready,
  output logic [DATA_W-1:0] pad_data_o,
  output logic              pad_data_oe,
  input  logic [DATA_W-1:0] pad_data_i,
  output logic [DATA_W-1:0] data_in
);
  localparam int TW = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;
  localparam logic [TW-1:0] TC_LAST = TW'(TURN_CYCLES - 1);

  logic [ADDR_W-1:0] addr_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic [DATA_W-1:0] dout_q, din_q;
  logic              irq0_prev_q, nmi_q, nmi_d;
  logic              drive_q;
  bus_state_e        state_q, state_d;
  logic [TW-1:0]     tcnt_q, tcnt_d;

  for (genvar g = 0; g < N_IRQ; g++) begin : g_irq
    pad_irq_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_filt (
      .clk     (clk),
      .reset   (reset),
      .pin_n_i (pad_irq_n[g]),
      .irq_n_o (irq_n[g])
    );
  end

  // A fresh filtered falling edge beats a simultaneous acknowledge.
  always_comb begin
    nmi_d = nmi_q;
    if (irq0_prev_q && !irq_n[0]) nmi_d = 1'b1;
    else if (nmi_ack)             nmi_d = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    case (state_q)
      ST_IN: if (data_out_en) begin
        state_d = ST_TURN_OUT;
        tcnt_d  = '0;
      end
      ST_TURN_OUT: begin
        if (!data_out_en)          state_d = ST_IN;
        else if (tcnt_q == TC_LAST) state_d = ST_OUT;
        else                        tcnt_d  = tcnt_q + 1'b1;
      end
      ST_OUT: if (!data_out_en) begin
        state_d = ST_TURN_IN;
        tcnt_d  = '0;
      end
      ST_TURN_IN: begin
        if (tcnt_q == TC_LAST) state_d = ST_IN;
        else                   tcnt_d  = tcnt_q + 1'b1;
      end
      default: state_d = ST_IN;
    endcase
  end

  // Output enable is a flop decoded from next state, never core-driven directly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q      <= '0;
      ctrl_q      <= {CTRL_W{STROBE_IDLE}};
      dout_q      <= '0;
      din_q       <= '0;
      irq0_prev_q <= 1'b1;
      nmi_q       <= 1'b0;
      drive_q     <= 1'b0;
      state_q     <= ST_IN;
      tcnt_q      <= '0;
    end else begin
      addr_q      <= addr;
      ctrl_q      <= ctrl_n;
      dout_q      <= data_out;
      irq0_prev_q <= irq_n[0];
      nmi_q       <= nmi_d;
      drive_q     <= (state_d == ST_OUT);
      state_q     <= state_d;
      tcnt_q      <= tcnt_d;
      if (state_q == ST_IN) din_q <= pad_data_i;
    end
  end

  assign pad_addr    = addr_q;
  assign pad_ctrl_n  = ctrl_q;
  assign pad_data_o  = dout_q;
  assign data_in     = din_q;
  assign nmi_pending = nmi_q;
  assign pad_data_oe = drive_q;
  assign drive_ready = drive_q;

endmodule
